// File: rtl/multi_timer.sv
// Multi-channel down-counting timer for the 6502 bus: per-channel prescaler,
// one-shot/periodic modes, multi-byte COUNT snapshot and a shared IRQ.
module multi_timer #(
    parameter int unsigned N_CH   = 4,
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned ADDR_W = $clog2(N_CH) + 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cs,
    input  logic              rwb,
    input  logic [ADDR_W-1:0] addr,
    input  logic [7:0]        i_data,
    output logic [7:0]        o_data,
    output logic              irqb
);

    localparam int unsigned CF_W    = (ADDR_W > 4) ? ADDR_W - 4 : 1;
    localparam int unsigned N_BYTES = WIDTH / 8;

    logic [CF_W-1:0] ch_sel;
    logic [3:0]      off;
    logic            wr_en;
    logic            rd_en;

    logic [N_CH-1:0] en_q, en_d;
    logic [N_CH-1:0] periodic_q, periodic_d;
    logic [N_CH-1:0] ie_q, ie_d;
    logic [N_CH-1:0] flag_q, flag_d;
    logic [7:0]       prescale_q [N_CH];
    logic [7:0]       prescale_d [N_CH];
    logic [7:0]       pcnt_q     [N_CH];
    logic [7:0]       pcnt_d     [N_CH];
    logic [WIDTH-1:0] reload_q   [N_CH];
    logic [WIDTH-1:0] reload_d   [N_CH];
    logic [WIDTH-1:0] count_q    [N_CH];
    logic [WIDTH-1:0] count_d    [N_CH];
    logic [WIDTH-1:0] snap_q     [N_CH];
    logic [WIDTH-1:0] snap_d     [N_CH];
    logic             irqb_q, irqb_d;

    logic [N_CH-1:0] ch_hit;
    logic [N_CH-1:0] tick;
    logic [N_CH-1:0] flag_set;
    logic [N_CH-1:0] flag_clr;

    // Keep the full channel field so indices >= N_CH never alias a real channel.
    generate
        if (ADDR_W > 4) begin : g_ch_field
            assign ch_sel = addr[ADDR_W-1:4];
        end else begin : g_ch_none
            assign ch_sel = '0;
        end
    endgenerate

    assign off   = addr[3:0];
    assign wr_en = cs & ~rwb;
    assign rd_en = cs & rwb;
    assign irqb  = irqb_q;

    always_comb begin
        ch_hit = '0;
        tick   = '0;
        for (int i = 0; i < N_CH; i++) begin
            ch_hit[i] = (ch_sel == CF_W'(i));
            // >= rather than == so lowering PRESCALE mid-count cannot strand pcnt.
            tick[i]   = en_q[i] && (pcnt_q[i] >= prescale_q[i]);
        end
    end

    always_comb begin
        en_d       = en_q;
        periodic_d = periodic_q;
        ie_d       = ie_q;
        flag_d     = flag_q;
        prescale_d = prescale_q;
        pcnt_d     = pcnt_q;
        reload_d   = reload_q;
        count_d    = count_q;
        snap_d     = snap_q;
        flag_set   = '0;
        flag_clr   = '0;
        irqb_d     = ~|(flag_q & ie_q);

        for (int i = 0; i < N_CH; i++) begin
            if (en_q[i]) begin
                pcnt_d[i] = tick[i] ? 8'd0 : pcnt_q[i] + 8'd1;
            end

            if (tick[i]) begin
                if (count_q[i] != '0) begin
                    count_d[i] = count_q[i] - WIDTH'(1);
                end else begin
                    flag_set[i] = 1'b1;
                    if (periodic_q[i]) begin
                        count_d[i] = reload_q[i];
                    end else begin
                        en_d[i] = 1'b0;
                    end
                end
            end

            if (wr_en && ch_hit[i]) begin
                case (off)
                    4'd0: begin
                        en_d[i]       = i_data[0];
                        periodic_d[i] = i_data[1];
                        ie_d[i]       = i_data[2];
                        if ((i_data[0] && !en_q[i]) || i_data[3]) begin
                            count_d[i] = reload_q[i];
                            pcnt_d[i]  = 8'd0;
                        end
                    end
                    4'd1:    flag_clr[i]   = i_data[0];
                    4'd2:    prescale_d[i] = i_data;
                    default: ;
                endcase
                for (int b = 0; b < N_BYTES; b++) begin
                    if (off == 4'(4 + b)) begin
                        reload_d[i][8*b +: 8] = i_data;
                    end
                end
            end

            if (rd_en && ch_hit[i] && (off == 4'd8)) begin
                snap_d[i] = count_q[i];
            end

            // A tick setting FLAG beats a same-cycle write-1-clear.
            flag_d[i] = (flag_q[i] & ~flag_clr[i]) | flag_set[i];
        end
    end

    always_comb begin
        o_data = 8'h00;
        if (cs) begin
            for (int i = 0; i < N_CH; i++) begin
                if (ch_hit[i]) begin
                    case (off)
                        4'd0:    o_data = {5'b0, ie_q[i], periodic_q[i], en_q[i]};
                        4'd1:    o_data = {6'b0, en_q[i], flag_q[i]};
                        4'd2:    o_data = prescale_q[i];
                        4'd8:    o_data = count_q[i][7:0];
                        default: begin
                            for (int b = 0; b < N_BYTES; b++) begin
                                if (off == 4'(4 + b)) begin
                                    o_data = reload_q[i][8*b +: 8];
                                end
                            end
                            for (int b = 1; b < N_BYTES; b++) begin
                                if (off == 4'(8 + b)) begin
                                    o_data = snap_q[i][8*b +: 8];
                                end
                            end
                        end
                    endcase
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            en_q       <= '0;
            periodic_q <= '0;
            ie_q       <= '0;
            flag_q     <= '0;
            prescale_q <= '{default: '0};
            pcnt_q     <= '{default: '0};
            reload_q   <= '{default: '0};
            count_q    <= '{default: '0};
            snap_q     <= '{default: '0};
            irqb_q     <= 1'b1;
        end else begin
            en_q       <= en_d;
            periodic_q <= periodic_d;
            ie_q       <= ie_d;
            flag_q     <= flag_d;
            prescale_q <= prescale_d;
            pcnt_q     <= pcnt_d;
            reload_q   <= reload_d;
            count_q    <= count_d;
            snap_q     <= snap_d;
            irqb_q     <= irqb_d;
        end
    end

endmodule
